// File: rtl/piezo_alert_sched.sv
// piezo_alert_sched
// Picks one of four piezo alert sources by fixed priority and plays a tone burst for it.
// The priority order is over-speed, battery-low, power-up chirp, then moving.
// Each source has its own tone pitch and its own ON/OFF cadence.
// The piezo pins are driven differentially while a burst is ON.
// Both pins are held low while OFF or idle, so no DC is left across the element.
module piezo_alert_sched #(
   parameter int FAST_SIM = 0,
   parameter int TICK_DIV = 50000,
   parameter int HP_OVR   = 6250,
   parameter int HP_BATT  = 12500,
   parameter int HP_CHIRP = 8333,
   parameter int HP_MOVE  = 25000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       ovr_spd,
   input  logic       batt_low,
   input  logic       moving,
   input  logic       pwr_up,
   output logic       piezo,
   output logic       piezo_n,
   output logic       active,
   output logic [2:0] src
);

   // Effective time constants: short values keep simulations fast
   localparam int TICK_DIV_E = (FAST_SIM != 0) ? 8 : TICK_DIV;
   localparam int HP_OVR_E   = (FAST_SIM != 0) ? 2 : HP_OVR;
   localparam int HP_BATT_E  = (FAST_SIM != 0) ? 3 : HP_BATT;
   localparam int HP_CHIRP_E = (FAST_SIM != 0) ? 4 : HP_CHIRP;
   localparam int HP_MOVE_E  = (FAST_SIM != 0) ? 5 : HP_MOVE;

   localparam int HP_MAX_A = (HP_OVR_E > HP_BATT_E) ? HP_OVR_E : HP_BATT_E;
   localparam int HP_MAX_B = (HP_CHIRP_E > HP_MOVE_E) ? HP_CHIRP_E : HP_MOVE_E;
   localparam int HP_MAX   = (HP_MAX_A > HP_MAX_B) ? HP_MAX_A : HP_MAX_B;

   localparam int PW = (TICK_DIV_E > 1) ? $clog2(TICK_DIV_E) : 1;
   localparam int TW = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV_E - 1);

   localparam logic [TW-1:0] HPL_OVR   = TW'(HP_OVR_E - 1);
   localparam logic [TW-1:0] HPL_BATT  = TW'(HP_BATT_E - 1);
   localparam logic [TW-1:0] HPL_CHIRP = TW'(HP_CHIRP_E - 1);
   localparam logic [TW-1:0] HPL_MOVE  = TW'(HP_MOVE_E - 1);

   // Source codes as reported on src
   localparam logic [2:0] SRC_NONE  = 3'd0;
   localparam logic [2:0] SRC_MOVE  = 3'd1;
   localparam logic [2:0] SRC_CHIRP = 3'd2;
   localparam logic [2:0] SRC_BATT  = 3'd3;
   localparam logic [2:0] SRC_OVR   = 3'd4;

   // Cadence lengths in ticks. These do not change in fast simulation; only the tick does.
   localparam logic [10:0] ON_OVR    = 11'd100;
   localparam logic [10:0] OFF_OVR   = 11'd100;
   localparam logic [10:0] ON_BATT   = 11'd250;
   localparam logic [10:0] OFF_BATT  = 11'd750;
   localparam logic [10:0] ON_CHIRP  = 11'd150;
   localparam logic [10:0] OFF_CHIRP = 11'd0;
   localparam logic [10:0] ON_MOVE   = 11'd50;
   localparam logic [10:0] OFF_MOVE  = 11'd1950;

   typedef enum logic [1:0] {
      IDLE,
      ON,
      OFF
   } state_t;

   state_t        state;
   logic          chirp_pend;
   logic [PW-1:0] presc;
   logic [10:0]   tick;
   logic [TW-1:0] tone;

   logic [2:0]    win_src;
   logic [TW-1:0] hp_last;
   logic [10:0]   on_len;
   logic [10:0]   off_len;
   logic [10:0]   phase_len;
   logic          presc_last;
   logic          phase_done;
   logic          preempt;
   logic          start_burst;
   logic [2:0]    start_src;
   logic          go_off;
   logic          go_idle;

   // Fixed-priority arbitration over the live requests and the latched chirp
   always_comb begin
      win_src = SRC_NONE;
      if (ovr_spd) begin
         win_src = SRC_OVR;
      end else if (batt_low) begin
         win_src = SRC_BATT;
      end else if (chirp_pend) begin
         win_src = SRC_CHIRP;
      end else if (moving) begin
         win_src = SRC_MOVE;
      end
   end

   // Tone pitch and cadence of the source currently being served
   always_comb begin
      hp_last = HPL_MOVE;
      on_len  = ON_MOVE;
      off_len = OFF_MOVE;
      case (src)
         SRC_OVR: begin
            hp_last = HPL_OVR;
            on_len  = ON_OVR;
            off_len = OFF_OVR;
         end
         SRC_BATT: begin
            hp_last = HPL_BATT;
            on_len  = ON_BATT;
            off_len = OFF_BATT;
         end
         SRC_CHIRP: begin
            hp_last = HPL_CHIRP;
            on_len  = ON_CHIRP;
            off_len = OFF_CHIRP;
         end
         default: begin
            hp_last = HPL_MOVE;
            on_len  = ON_MOVE;
            off_len = OFF_MOVE;
         end
      endcase
   end

   // Phase end is the last clock of the last tick, so a phase lasts exactly len*TICK_DIV clocks
   always_comb begin
      phase_len  = (state == ON) ? on_len : off_len;
      presc_last = (presc == PRESC_LAST);
      phase_done = presc_last && (tick == (phase_len - 11'd1));
      preempt    = ovr_spd && (src != SRC_OVR);
   end

   // Decide the next phase. Over-speed preempts any lower source at any point in a burst.
   always_comb begin
      start_burst = 1'b0;
      start_src   = win_src;
      go_off      = 1'b0;
      go_idle     = 1'b0;
      case (state)
         IDLE: begin
            start_burst = (win_src != SRC_NONE);
         end
         ON: begin
            if (preempt) begin
               start_burst = 1'b1;
               start_src   = SRC_OVR;
            end else if (phase_done) begin
               if (src == SRC_CHIRP) begin
                  go_idle = 1'b1;
               end else begin
                  go_off = 1'b1;
               end
            end
         end
         OFF: begin
            if (preempt) begin
               start_burst = 1'b1;
               start_src   = SRC_OVR;
            end else if (phase_done) begin
               if (win_src != SRC_NONE) begin
                  start_burst = 1'b1;
               end else begin
                  go_idle = 1'b1;
               end
            end
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase
   end

   // Burst sequencer: state, timers, pin drive and the chirp latch, all registered together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         chirp_pend <= 1'b0;
         presc      <= '0;
         tick       <= '0;
         tone       <= '0;
         piezo      <= 1'b0;
         piezo_n    <= 1'b0;
         active     <= 1'b0;
         src        <= SRC_NONE;
      end else begin
         if (!en || go_idle) begin
            state   <= IDLE;
            presc   <= '0;
            tick    <= '0;
            tone    <= '0;
            piezo   <= 1'b0;
            piezo_n <= 1'b0;
            active  <= 1'b0;
            src     <= SRC_NONE;
         end else if (start_burst) begin
            state   <= ON;
            presc   <= '0;
            tick    <= '0;
            tone    <= '0;
            piezo   <= 1'b1;
            piezo_n <= 1'b0;
            active  <= 1'b1;
            src     <= start_src;
            if (start_src == SRC_CHIRP) begin
               chirp_pend <= 1'b0;
            end
         end else if (go_off) begin
            state   <= OFF;
            presc   <= '0;
            tick    <= '0;
            tone    <= '0;
            piezo   <= 1'b0;
            piezo_n <= 1'b0;
         end else if (state != IDLE) begin
            if (presc_last) begin
               presc <= '0;
               tick  <= tick + 11'd1;
            end else begin
               presc <= presc + 1'b1;
            end
            if (state == ON) begin
               if (tone == hp_last) begin
                  tone    <= '0;
                  piezo   <= ~piezo;
                  piezo_n <= piezo;
               end else begin
                  tone <= tone + 1'b1;
               end
            end
         end
         if (pwr_up) begin
            chirp_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_piezo_alert_sched.sv
// tb_piezo_alert_sched
// Directed bench for piezo_alert_sched built with FAST_SIM=1.
// In that build one tick is 8 clocks.
// The tone half-periods are ovr 2, batt 3, chirp 4 and move 5 clocks.
// The observed word is {piezo, piezo_n, active, src}.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at the same point.
module tb_piezo_alert_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       ovr_spd;
   logic       batt_low;
   logic       moving;
   logic       pwr_up;
   logic       piezo;
   logic       piezo_n;
   logic       active;
   logic [2:0] src;

   int checks = 0;
   int errors = 0;

   piezo_alert_sched #(
      .FAST_SIM(1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .ovr_spd  (ovr_spd),
      .batt_low (batt_low),
      .moving   (moving),
      .pwr_up   (pwr_up),
      .piezo    (piezo),
      .piezo_n  (piezo_n),
      .active   (active),
      .src      (src)
   );

   // 10-unit system clock
   always #5 clk = ~clk;

   function automatic logic [31:0] obs();
      return {26'd0, piezo, piezo_n, active, src};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic e, input logic o, input logic b,
                                input logic m, input logic p);
      en       = e;
      ovr_spd  = o;
      batt_low = b;
      moving   = m;
      pwr_up   = p;
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   // ON cycles k0..k1-1 of a burst: piezo is high for the first half-period, then alternates
   task automatic checkOn(input string tag, input logic [2:0] s, input int hp,
                          input int k0, input int k1);
      for (int k = k0; k < k1; k++) begin
         logic p;
         p = (((k / hp) % 2) == 0);
         checkOutput(tag, obs(), {26'd0, p, ~p, 1'b1, s});
         step(1);
      end
   endtask

   task automatic checkOff(input string tag, input logic [2:0] s, input int n);
      for (int k = 0; k < n; k++) begin
         checkOutput(tag, obs(), {26'd0, 1'b0, 1'b0, 1'b1, s});
         step(1);
      end
   endtask

   task automatic checkIdle(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         checkOutput(tag, obs(), 32'd0);
         step(1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(2);
      checkOutput("reset_state", obs(), 32'd0);
      rst_n = 1'b1;
      step(1);
      checkIdle("idle_no_req", 3);

      $display("[TB] reset in the middle of an over-speed burst");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      checkOn("t1_ovr_on", 3'd4, 2, 0, 6);
      rst_n = 1'b0;
      #1;
      checkOutput("t1_async_reset", obs(), 32'd0);
      step(1);
      checkOutput("t1_reset_held", obs(), 32'd0);
      rst_n = 1'b1;
      step(1);
      checkOn("t1_restart", 3'd4, 2, 0, 4);

      $display("[TB] over-speed cadence 800 on / 800 off");
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      checkOn("t2_ovr_on", 3'd4, 2, 0, 800);
      checkOff("t2_ovr_off", 3'd4, 800);
      checkOn("t2_ovr_on2", 3'd4, 2, 0, 8);

      $display("[TB] move burst, batt does not preempt, ovr preempts in OFF");
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1);
      checkOn("t3_move_on", 3'd1, 5, 0, 400);
      checkOff("t3_move_off", 3'd1, 50);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOff("t3_no_batt_preempt", 3'd1, 50);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1);
      checkOn("t3_ovr_preempt", 3'd4, 2, 0, 8);

      $display("[TB] chirp waits behind battery-low");
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOn("t4_batt_on", 3'd3, 3, 0, 2000);
      checkOff("t4_batt_off", 3'd3, 10);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOff("t4_batt_off", 3'd3, 5990);
      checkOn("t4_chirp_on", 3'd2, 4, 0, 600);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOn("t4_chirp_on", 3'd2, 4, 600, 1200);
      checkIdle("t4_chirp_end", 1);
      checkOn("t4_batt_resume", 3'd3, 3, 0, 2000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOff("t4_batt_off2", 3'd3, 6000);
      checkIdle("t4_pend_cleared", 3);

      $display("[TB] mute and unmute");
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1);
      checkOn("t5_move_on", 3'd1, 5, 0, 20);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1);
      checkIdle("t5_muted", 4);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1);
      checkOn("t5_unmute", 3'd1, 5, 0, 20);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkIdle("t5_mute_pwrup", 3);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1);
      checkOn("t5_chirp_kept", 3'd2, 4, 0, 16);

      $display("[TB] battery-low removed early in ON");
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1);
      checkOn("t6_batt_on", 3'd3, 3, 0, 10);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOn("t6_batt_on", 3'd3, 3, 10, 2000);
      checkOff("t6_batt_off", 3'd3, 6000);
      checkIdle("t6_idle", 4);

      $display("[TB] chirp preempted by over-speed is lost");
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t7_pend_latency", obs(), 32'd0);
      step(1);
      checkOn("t7_chirp_on", 3'd2, 4, 0, 20);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      checkOn("t7_ovr_on", 3'd4, 2, 0, 800);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOff("t7_ovr_off", 3'd4, 800);
      checkIdle("t7_chirp_lost", 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/piezo_alert_sched.md
Name: piezo_alert_sched

Overview:
- Alert scheduler for the Segway piezo buzzer.
- Arbitrates four alert sources by fixed priority: over-speed, battery-low, power-up chirp and moving.
- For the winning source, sequences a tone burst with a per-source tone frequency and on/off cadence.
- Drives the differential piezo pins and reports the source currently being served.
- Sits between the balance/battery monitors and the piezo pins.

Parameters:
- FAST_SIM, 0, when 1 every time constant is replaced by its simulation value (listed below).
- TICK_DIV, 50000, clocks per cadence tick (1 ms at 50 MHz). FAST_SIM value: 8.
- HP_OVR, 6250, tone half-period in clocks for over-speed. FAST_SIM value: 2.
- HP_BATT, 12500, tone half-period for battery-low. FAST_SIM value: 3.
- HP_CHIRP, 8333, tone half-period for chirp. FAST_SIM value: 4.
- HP_MOVE, 25000, tone half-period for moving. FAST_SIM value: 5.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; low mutes the block.
- ovr_spd  input  1  over-speed level request.
- batt_low  input  1  battery-low level request.
- moving  input  1  rider-moving level request.
- pwr_up  input  1  single-cycle pulse that requests one chirp.
- piezo  output  1  piezo drive, positive pin.
- piezo_n  output  1  piezo drive, negative pin.
- active  output  1  high while in the ON or OFF phase.
- src  output  3  source being served: 0 none, 1 move, 2 chirp, 3 batt, 4 ovr.

Behaviour:
- Clocking and reset:
  - Clock port is clk. Reset port rst_n is asynchronous and active-low.
  - Reset values: piezo=0, piezo_n=0, active=0, src=0, state=IDLE, chirp_pend=0, all counters 0.
- Chirp pending flag:
  - pwr_up sets chirp_pend. Setting takes priority over clearing in the same cycle.
  - chirp_pend clears when a chirp burst enters ON.
- Priority: ovr(4) > batt(3) > chirp_pend(2) > moving(1).
- Cadence, in ticks (ON/OFF):
  - ovr: 100/100.
  - batt: 250/750.
  - chirp: 150/0. No OFF phase; goes straight to IDLE.
  - move: 50/1950.
- State machine, states IDLE, ON, OFF:
  - IDLE: if en=1 and any request is present, go to ON with the highest-priority source on the next clock. Else stay in IDLE; src=0.
  - ON:
    - Tone counter counts 0..HP-1. At HP-1 it wraps and piezo toggles.
    - piezo=1 on the first ON cycle; piezo_n=~piezo throughout ON.
    - When the tick count reaches the ON length, go to OFF (or to IDLE for chirp).
  - OFF:
    - piezo=0 and piezo_n=0; no DC is applied across the piezo.
    - When the tick count reaches the OFF length, re-arbitrate. Go to ON with the current highest-priority source, or to IDLE if none.
- Timing:
  - The tick prescaler and tick counter restart on every phase entry, so each phase lasts exactly length×TICK_DIV clocks.
  - The tone counter restarts on ON entry.
- Latency: a request sampled in IDLE gives active=1 and piezo=1 on the next clock edge.
- Preemption:
  - ovr_spd asserted while serving any lower source, in ON or OFF, forces ON with src=4 on the next clock. Timers restart.
  - No other source preempts.
  - A preempted chirp is lost (chirp_pend already cleared).
- Request removal: deassertion of the served level source does not truncate the burst. ON and OFF complete, then re-arbitration occurs.
- Mute: en=0 forces IDLE and silent outputs on the next clock. chirp_pend is retained.
- src and active are registered and change in the same cycle as the state change.
- Counter widths:
  - Tick prescaler: clog2(TICK_DIV).
  - Tick counter: 11 bits.
  - Tone counter: clog2(max HP).
  - No counter may overflow at the defaults.

Test Plan (FAST_SIM=1; tick = 8 clocks):
1. Reset mid-burst: assert ovr_spd, then pulse rst_n low during ON → all outputs 0 immediately, asynchronously. After release with ovr_spd still high, ON restarts one clock later.
2. ovr_spd held high → src=4. piezo toggles every 2 clocks with piezo_n=~piezo for 800 clocks, then both 0 for 800 clocks, repeating.
3. moving high, then ovr_spd asserted 100 clocks into the move OFF phase → next clock src=4, active=1, piezo=1, tone period 4 clocks.
4. pwr_up pulse with batt_low high → a batt burst runs first (ON 2000 clocks, OFF 6000 clocks). Then the chirp runs: src=2 for 1200 clocks, half-period 4, no OFF. Then batt resumes.
5. moving held, en dropped during ON → silent, src=0 next clock. en restored → new move burst starts next clock.
6. batt_low dropped at clock 10 of ON → the burst completes its full 2000/6000 clocks, then IDLE with src=0.
